// File: rtl/vu_sample_sequencer.sv
// vu_sample_sequencer: ADC sample sequencing with windowed maximum, peak-hold/decay and display handshake
module vu_sample_sequencer #(
  parameter int DW    = 8,
  parameter int NSAMP = 16,
  parameter int HOLD  = 8,
  parameter int DECAY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          enable,
  output logic          adc_req,
  input  logic          adc_ack,
  input  logic [DW-1:0] adc_data,
  output logic [DW-1:0] level,
  output logic [DW-1:0] peak,
  output logic          disp_valid,
  input  logic          disp_ready,
  output logic          overrun,
  output logic          busy
);
  localparam int CW = $clog2(NSAMP);
  typedef enum logic [1:0] {IDLE, REQ, PUB} state_t;
  state_t        state;
  logic [DW-1:0] win_max;
  logic [DW-1:0] new_max;
  logic [DW-1:0] dec;
  logic [CW-1:0] cnt;
  logic [7:0]    hold_cnt;
  logic          last;
  assign new_max = adc_data > win_max ? adc_data : win_max;
  assign dec     = peak >= DW'(DECAY) ? peak - DW'(DECAY) : '0;
  assign last    = cnt == CW'(NSAMP - 1);
  // sequencer FSM with registered outputs, window max and peak-hold tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      adc_req    <= 1'b0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      level      <= '0;
      peak       <= '0;
      win_max    <= '0;
      cnt        <= '0;
      hold_cnt   <= '0;
    end else begin
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick && enable) begin
          state   <= REQ;
          adc_req <= 1'b1;
          busy    <= 1'b1;
        end
        REQ: if (adc_ack) begin
          adc_req <= 1'b0;
          win_max <= new_max;
          if (last) begin
            state      <= PUB;
            cnt        <= '0;
            disp_valid <= 1'b1;
            level      <= new_max;
            if (new_max >= peak) begin
              peak     <= new_max;
              hold_cnt <= '0;
            end else if (hold_cnt < 8'(HOLD)) hold_cnt <= hold_cnt + 8'd1;
            else peak <= dec > new_max ? dec : new_max;
          end else begin
            state <= IDLE;
            cnt   <= cnt + CW'(1);
            busy  <= 1'b0;
          end
        end
        PUB: if (disp_ready) begin
          state      <= IDLE;
          disp_valid <= 1'b0;
          busy       <= 1'b0;
          win_max    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
